imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory from a byte stream (UART/debug link) before the core runs. Receives a little-endian word count, then that many 32-bit little-endian instruction words, and drives the instruction memory's write port word by word. Holds the core in reset until a complete, valid image is written. Sits between the host link receiver and the instruction memory write port; it is the writer side of the fetch read port.

## Interface
- DEPTH, 4096: instruction memory depth in 32-bit words
- AW, $clog2(DEPTH): word address width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  loader accepts a byte this cycle
- we_o  out  1  memory write strobe, one cycle per word
- waddr_o  out  AW  word index, equals pc[AW+1:2] of the written instruction
- wdata_o  out  32  instruction word
- busy_o  out  1  load in progress (LEN, DATA, CSUM)
- done_o  out  1  image loaded successfully (DONE)
- err_o  out  1  load failed (ERR)
- core_rst_o  out  1  core reset request; low only in DONE

## Operation
- States: IDLE, LEN, DATA, CSUM (only with checksum), DONE, ERR.
- IDLE: start_i -> LEN; waddr and byte counter cleared, checksum accumulator cleared.
- Byte transfer occurs on a rising edge with rx_valid_i & rx_ready_o. rx_ready_o = 1 in LEN, DATA, CSUM; 0 elsewhere (decoded from state).
- LEN: four bytes, first byte = bits [7:0], form 32-bit count N.
  - N == 0 -> CSUM if enabled, else DONE.
  - N > DEPTH -> ERR.
  - else -> DATA.
- DATA: every four accepted bytes form one word (first byte -> wdata[7:0]); write issued; waddr increments after each write; after write N, -> CSUM or DONE.
- CSUM: four bytes form expected sum; equal to sum of all N data words modulo 2^32 -> DONE, else -> ERR. Length word excluded from the sum.
- DONE/ERR: hold until start_i, which re-enters LEN with cleared counters. core_rst_o rises again on that edge.
- start_i in LEN/DATA/CSUM is ignored.
- Bytes presented in IDLE/DONE/ERR are not accepted (rx_ready_o = 0).

## Timing
- Reset values: rx_ready_o 0, we_o 0, waddr_o 0, wdata_o 0, busy_o 0, done_o 0, err_o 0, core_rst_o 1; state IDLE.
- rst_i asserted mid-load aborts immediately; no further writes; partially written memory is not cleared.
- we_o, waddr_o, wdata_o are registered: we_o high exactly one cycle, in the cycle after the 4th byte of a word is accepted; waddr_o/wdata_o stable while we_o is high.
- Back-to-back bytes at one per cycle are sustained; gaps in rx_valid_i stall without loss.
- Transition to DONE happens on the edge after the last write strobe (no CSUM) or after the 4th CSUM byte; done_o and core_rst_o=0 are visible in that same next cycle.
- N == DEPTH is legal; last write at waddr_o = DEPTH-1, no wrap.
- Word count held in 32 bits; comparison against DEPTH is unsigned.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: CSUM state, 32-bit accumulator and mismatch -> ERR exist.
- Undefined: no CSUM state; after the Nth word (or N == 0) the loader goes directly to DONE; err_o only from N > DEPTH.

## Structure
- imem_loader_pkg: state enum, protocol constants (bytes per word = 4, length field width = 32).
- Sub-module imem_loader_word_asm: shifts in bytes, 2-bit byte counter, pulses word_valid with assembled little-endian word; reused for LEN, DATA and CSUM fields.

## Test plan
- start_i, stream 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes (0, 0x00000013), (1, 0x00100093); done_o=1, core_rst_o=0.
- Length bytes 01 10 00 00 (N=4097) with DEPTH=4096 -> ERR, err_o=1, no we_o pulse, core_rst_o=1.
- N=1 word 0xDEADBEEF, rx_valid_i toggled every other cycle -> single write at waddr 0, data 0xDEADBEEF.
- With IMEM_LOADER_CHECKSUM_EN: words 0x00000013, 0x00100093, checksum 0x001000A6 -> DONE; checksum 0x001000A7 -> ERR.
- rst_i pulsed after 2 of 3 words -> outputs at reset values immediately, no third write; new start_i + full image -> DONE.
- N=0 -> DONE with zero writes (checksum 0 required when enabled); then start_i -> busy_o=1, core_rst_o=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader states and stream framing constants; S_CSUM exists only with IMEM_LOADER_CHECKSUM_EN
package imem_loader_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W = 32;
  localparam int BCW = $clog2(BYTES_PER_WORD);
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/imem_loader_word_asm.sv
// imem_loader_word_asm: gathers accepted bytes into little-endian 32-bit words, pulsing word_valid on the 4th byte
module imem_loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             byte_valid,
  input  logic [7:0]       din,
  output logic             word_valid,
  output logic [LEN_W-1:0] word
);
  logic [BCW-1:0] cnt;
  logic [LEN_W-9:0] sr;
  assign word_valid = byte_valid && cnt == BCW'(BYTES_PER_WORD - 1);
  assign word = {din, sr};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sr <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 1'b1;
      sr <= {din, sr[LEN_W-9:8]};
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes instruction memory from a length-prefixed byte stream and holds the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit word checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          we_o,
  output logic [AW-1:0] waddr_o,
  output logic [31:0]   wdata_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          core_rst_o
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
  logic [LEN_W-1:0] acc;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  state_t state, state_n;
  logic wv, last, start_ok;
  logic [LEN_W-1:0] word, n;
  logic [AW:0] wcnt;
  assign busy_o = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign done_o = state == S_DONE;
  assign err_o = state == S_ERR;
  assign core_rst_o = state != S_DONE;
  assign start_ok = start_i && !busy_o;
  // The cycle carrying the final write strobe accepts no bytes; the FSM leaves DATA on the following edge.
  assign last = state == S_DATA && LEN_W'(wcnt) == n;
  assign rx_ready_o = busy_o && !last;
  imem_loader_word_asm u_asm (
    .clk(clk_i),
    .rst(rst_i),
    .clr(start_ok),
    .byte_valid(rx_valid_i && rx_ready_o),
    .din(rx_data_i),
    .word_valid(wv),
    .word(word)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_LEN: if (wv) state_n = word == '0 ? S_FIN : word > LEN_W'(DEPTH) ? S_ERR : S_DATA;
      S_DATA: if (last) state_n = S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (wv) state_n = word == acc ? S_DONE : S_ERR;
`endif
      default: if (start_i) state_n = S_LEN;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      we_o <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
      n <= '0;
      wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc <= '0;
`endif
    end else begin
      we_o <= state == S_DATA && wv;
      if (start_ok) begin
        waddr_o <= '0;
        wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc <= '0;
`endif
      end
      if (state == S_LEN && wv) n <= word;
      if (state == S_DATA && wv) begin
        wdata_o <= word;
        waddr_o <= wcnt[AW-1:0];
        wcnt <= wcnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc <= acc + word;
`endif
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; each write strobe is popped against the expected (addr, data) queue
module tb_imem_loader;
  localparam int DEPTH = 4096;
  localparam int AW = 12;
  logic clk = 0, rst = 1, start_i = 0, rx_valid_i = 0;
  logic [7:0] rx_data_i = 0;
  logic rx_ready_o, we_o, busy_o, done_o, err_o, core_rst_o;
  logic [AW-1:0] waddr_o;
  logic [31:0] wdata_o;
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  logic [31:0] img[$];
  int checks = 0, passed = 0, nwr = 0, n0;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_o(core_rst_o)
  );

  always @(negedge clk)
    if (!rst && we_o) begin
      wr_t e;
      nwr++;
      checks++;
      if (exp_q.size() == 0) $display("FAIL write_unexpected got addr=%0d data=%h exp none", waddr_o, wdata_o);
      else begin
        e = exp_q.pop_front();
        if ({waddr_o, wdata_o} !== e) $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h", waddr_o, wdata_o, e.a, e.d);
        else passed++;
      end
    end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_data_i = b;
    rx_valid_i = 1;
    while (!rx_ready_o && t < 20) begin @(negedge clk); t++; end
    if (!rx_ready_o) begin checks++; $display("FAIL rx_ready_timeout got=0 exp=1"); end
    @(negedge clk);
    rx_valid_i = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic load(input logic [31:0] n, input logic [31:0] cdelta, input int gap);
    logic [31:0] sum;
    sum = cdelta;
    send_word(n, gap);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({AW'(i), img[i]});
      sum += img[i];
      send_word(img[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum, gap);
`endif
  endtask

  task automatic do_start();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_end();
    int t = 0;
    while (!done_o && !err_o && t < 20) begin @(negedge clk); t++; end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready_o, we_o, busy_o, done_o, err_o, core_rst_o} !== 6'b000001)
      $display("FAIL reset_ctrl got=%b exp=000001", {rx_ready_o, we_o, busy_o, done_o, err_o, core_rst_o});
    else passed++;
    checks++;
    if ({waddr_o, wdata_o} !== '0) $display("FAIL reset_data got=%h/%h exp=0/0", waddr_o, wdata_o);
    else passed++;
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    img.delete();
    img.push_back(32'h00000013);
    img.push_back(32'h00100093);
    n0 = nwr;
    do_start();
    checks++;
    if ({busy_o, rx_ready_o, core_rst_o} !== 3'b111) $display("FAIL basic_busy got=%b exp=111", {busy_o, rx_ready_o, core_rst_o});
    else passed++;
    load(2, 0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    checks++;
    if ({we_o, done_o, rx_ready_o} !== 3'b100) $display("FAIL basic_last_strobe got=%b exp=100", {we_o, done_o, rx_ready_o});
    else passed++;
    @(negedge clk);
`endif
    checks++;
    if ({done_o, err_o, core_rst_o, busy_o, rx_ready_o} !== 5'b10000)
      $display("FAIL basic_done got=%b exp=10000", {done_o, err_o, core_rst_o, busy_o, rx_ready_o});
    else passed++;
    checks++;
    if (nwr - n0 !== 2 || exp_q.size() !== 0) $display("FAIL basic_writes got=%0d left=%0d exp=2 left=0", nwr - n0, exp_q.size());
    else passed++;
  endtask

  task automatic test_too_long();
    n0 = nwr;
    do_start();
    send_word(32'h00001001, 0);
    checks++;
    if ({err_o, done_o, busy_o, core_rst_o, rx_ready_o} !== 5'b10010)
      $display("FAIL toolong_err got=%b exp=10010", {err_o, done_o, busy_o, core_rst_o, rx_ready_o});
    else passed++;
    rx_data_i = 8'h55;
    rx_valid_i = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready_o, err_o, nwr - n0} !== {2'b01, 32'd0}) $display("FAIL toolong_hold got ready=%b err=%b writes=%0d exp 0 1 0", rx_ready_o, err_o, nwr - n0);
    else passed++;
    rx_valid_i = 0;
  endtask

  task automatic test_gaps();
    n0 = nwr;
    do_start();
    exp_q.push_back({AW'(0), 32'hDEADBEEF});
    send_word(1, 1);
    do_start();
    send_word(32'hDEADBEEF, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hDEADBEEF, 1);
`endif
    wait_end();
    checks++;
    if ({done_o, err_o} !== 2'b10 || nwr - n0 !== 1 || exp_q.size() !== 0)
      $display("FAIL gaps got done=%b err=%b writes=%0d exp 1 0 1", done_o, err_o, nwr - n0);
    else passed++;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_csum_bad();
    img.delete();
    img.push_back(32'h00000013);
    img.push_back(32'h00100093);
    do_start();
    load(2, 1, 0);
    wait_end();
    checks++;
    if ({err_o, done_o, core_rst_o} !== 3'b101 || exp_q.size() !== 0)
      $display("FAIL csum_bad got=%b left=%0d exp=101 left=0", {err_o, done_o, core_rst_o}, exp_q.size());
    else passed++;
  endtask
`endif

  task automatic test_reset_abort();
    img.delete();
    img.push_back(32'h11111111);
    img.push_back(32'h22222222);
    img.push_back(32'h33333333);
    n0 = nwr;
    do_start();
    exp_q.push_back({AW'(0), img[0]});
    exp_q.push_back({AW'(1), img[1]});
    send_word(3, 0);
    send_word(img[0], 0);
    send_word(img[1], 0);
    send_byte(8'h33, 0);
    send_byte(8'h33, 0);
    rst = 1;
    #1;
    checks++;
    if ({rx_ready_o, we_o, busy_o, done_o, err_o, core_rst_o, waddr_o} !== {6'b000001, AW'(0)})
      $display("FAIL abort_reset got=%b exp=000001", {rx_ready_o, we_o, busy_o, done_o, err_o, core_rst_o});
    else passed++;
    @(negedge clk);
    rst = 0;
    rx_data_i = 8'h33;
    rx_valid_i = 1;
    repeat (6) @(negedge clk);
    rx_valid_i = 0;
    checks++;
    if (nwr - n0 !== 2 || busy_o !== 1'b0) $display("FAIL abort_nowrite got writes=%0d busy=%b exp 2 0", nwr - n0, busy_o);
    else passed++;
    do_start();
    load(3, 0, 0);
    wait_end();
    checks++;
    if ({done_o, core_rst_o} !== 2'b10 || nwr - n0 !== 5 || exp_q.size() !== 0)
      $display("FAIL abort_reload got done=%b writes=%0d exp 1 5", done_o, nwr - n0);
    else passed++;
  endtask

  task automatic test_zero();
    img.delete();
    n0 = nwr;
    do_start();
    load(0, 0, 0);
    wait_end();
    checks++;
    if ({done_o, err_o, core_rst_o} !== 3'b100 || nwr !== n0) $display("FAIL zero_done got=%b writes=%0d exp=100 0", {done_o, err_o, core_rst_o}, nwr - n0);
    else passed++;
    do_start();
    checks++;
    if ({busy_o, core_rst_o, done_o} !== 3'b110) $display("FAIL zero_restart got=%b exp=110", {busy_o, core_rst_o, done_o});
    else passed++;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_depth();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back(i * 32'h9E3779B9 + 32'h5);
    n0 = nwr;
    do_start();
    load(DEPTH, 0, 0);
    wait_end();
    checks++;
    if ({done_o, err_o} !== 2'b10 || nwr - n0 !== DEPTH || exp_q.size() !== 0)
      $display("FAIL depth got done=%b err=%b writes=%0d exp 1 0 %0d", done_o, err_o, nwr - n0, DEPTH);
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_too_long();
    test_gaps();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_csum_bad();
`endif
    test_reset_abort();
    test_zero();
    test_depth();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
